// File: rtl/seq_signed_div.sv
// seq_signed_div: restoring shift-subtract divider, one quotient bit per cycle, signed or unsigned.
// Define SEQ_DIV_ZERO_DETECT_EN to short-cut a zero divisor and raise div_by_zero.
module seq_signed_div #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] acc, dsr, rem;
   logic [WIDTH:0] diff;
   logic neg_q, neg_r, neg_a, neg_b, fits;
   assign neg_a = signed_mode & dividend[WIDTH-1];
   assign neg_b = signed_mode & divisor[WIDTH-1];
   // the partial remainder never reaches 2^WIDTH, so bit WIDTH of diff is the borrow
   assign diff = {rem, acc[WIDTH-1]} - {1'b0, dsr};
   assign fits = ~diff[WIDTH];
`ifdef SEQ_DIV_ZERO_DETECT_EN
   logic dz;
`else
   assign div_by_zero = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         dsr       <= '0;
         rem       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
         dz          <= 1'b0;
         div_by_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start && !done) begin
               acc   <= neg_a ? -dividend : dividend;
               dsr   <= neg_b ? -divisor : divisor;
               rem   <= '0;
               neg_q <= neg_a ^ neg_b;
               neg_r <= neg_a;
               cnt   <= CW'(WIDTH);
               busy  <= 1'b1;
               state <= RUN;
`ifdef SEQ_DIV_ZERO_DETECT_EN
               dz <= divisor == '0;
               if (divisor == '0) begin
                  acc   <= '1;
                  rem   <= dividend;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= FIX;
               end
`endif
            end
            RUN: begin
               rem   <= fits ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], acc[WIDTH-1]};
               acc   <= {acc[WIDTH-2:0], fits};
               cnt   <= cnt - CW'(1);
               state <= (cnt == CW'(1)) ? FIX : RUN;
            end
            FIX: begin
               acc   <= neg_q ? -acc : acc;
               rem   <= neg_r ? -rem : rem;
               state <= DONE;
            end
            DONE: begin
               quotient  <= acc;
               remainder <= rem;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
`ifdef SEQ_DIV_ZERO_DETECT_EN
               div_by_zero <= dz;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_signed_div.sv
// tb_seq_signed_div: directed corner cases plus random operands against an arithmetic reference.
module tb_seq_signed_div;
   localparam int W = 16;
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, signed_mode = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   int checks = 0, errors = 0;
   seq_signed_div #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic void model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
      int sa, sb;
      dz = 1'b0;
      if (b == '0) begin
         q = '1;
         r = a;
`ifdef SEQ_DIV_ZERO_DETECT_EN
         dz = 1'b1;
`else
         if (sm && a[W-1]) q = -q;
`endif
      end else if (sm) begin
         sa = int'(signed'(a));
         sb = int'(signed'(b));
         q = W'(sa / sb);
         r = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction
   task automatic run_op(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input string tag);
      logic [W-1:0] eq, er;
      bit ez;
      int cyc, lat;
      model(sm, a, b, eq, er, ez);
      lat = W + 2;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      if (b == '0) lat = 2;
`endif
      @(negedge clk);
      signed_mode = sm;
      dividend = a;
      divisor = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      signed_mode = 1'($urandom);
      dividend = W'($urandom);
      divisor = W'($urandom);
      chk({tag, "_busy"}, 32'(busy), 1);
      cyc = 0;
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_r"}, 32'(remainder), 32'(er));
      chk({tag, "_dz"}, 32'(div_by_zero), 32'(ez));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(done), 0);
      chk({tag, "_idle"}, 32'(busy), 0);
      chk({tag, "_hold"}, 32'(quotient), 32'(eq));
      start = 1'b0;
   endtask
   initial begin
      bit seen;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_q", 32'(quotient), 0);
      chk("rst_r", 32'(remainder), 0);
      chk("rst_dz", 32'(div_by_zero), 0);
      @(negedge clk) rst_n = 1'b1;
      run_op(1'b1, 16'hFFF9, 16'h0002, 1'b0, "s_m7_2");
      run_op(1'b0, 16'hFFF9, 16'h0002, 1'b0, "u_fff9_2");
      run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0, "s_ovf");
      run_op(1'b1, 16'h0005, 16'h0000, 1'b0, "s_5_0");
      run_op(1'b1, 16'hFFFB, 16'h0000, 1'b0, "s_m5_0");
      run_op(1'b0, 16'h8000, 16'h0000, 1'b0, "u_8000_0");
      run_op(1'b1, 16'h7FFF, 16'h8000, 1'b0, "s_max_min");
      run_op(1'b0, 16'd100, 16'd7, 1'b1, "held");
      run_op(1'b0, 16'd100, 16'd7, 1'b0, "repulse");
      @(negedge clk);
      signed_mode = 1'b0;
      dividend = 16'd1234;
      divisor = 16'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_q", 32'(quotient), 0);
      chk("mid_rst_r", 32'(remainder), 0);
      chk("mid_rst_dz", 32'(div_by_zero), 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      chk("mid_rst_no_done", 32'(seen), 0);
      run_op(1'b1, 16'hFF38, 16'd7, 1'b0, "after_rst");
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom);
         b = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom >> $urandom_range(15, 0));
         run_op(1'($urandom), a, b, 1'b0, "rand");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
